// File: rtl/word_serializer_pkg.sv
// Shared state encoding and handshake helper for the word serializer
// and its matching deserializer.
package word_serializer_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_SHIFT = 1'b1
    } state_e;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Load-side and serial-side handshake bundle of the word serializer.
// The serializer takes the slave modport; the feeding logic takes master.
interface word_serializer_if #(
    parameter int Width = 8
) ();

    logic             load_valid;
    logic             load_ready;
    logic [Width-1:0] D;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_bit;
    logic             tx_last;
    logic             busy;

    modport master (
        output load_valid, D, tx_ready,
        input  load_ready, tx_valid, tx_bit, tx_last, busy
    );

    modport slave (
        input  load_valid, D, tx_ready,
        output load_ready, tx_valid, tx_bit, tx_last, busy
    );

endinterface

// File: rtl/word_serializer_bit_down_counter.sv
// Loadable down counter with zero flag; it saturates at zero rather than
// wrapping, so callers can decrement unconditionally.
module bit_down_counter #(
    parameter int Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Load wins over decrement so a back-to-back reload on the last bit works.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word reader: loads a word via valid/ready and emits it
// one bit per accepted transfer, reloading on the last bit for full throughput.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int   Width    = 8,
    parameter bit   MsbFirst = 1'b1,
    parameter logic IdleBit  = 1'b0
) (
    input logic                clk,
    input logic                rst,
    word_serializer_if.slave   bus
);

    localparam int CntW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(Width - 1);

    state_e           state_q;
    state_e           state_d;
    logic [Width-1:0] shreg_q;
    logic [Width-1:0] shreg_d;
    logic             cnt_zero;
    logic             in_shift;
    logic             last_bit;
    logic             load_fire;
    logic             tx_fire;

    assign in_shift  = (state_q == STATE_SHIFT);
    assign last_bit  = in_shift & cnt_zero;
    assign tx_fire   = hs_fire(in_shift, bus.tx_ready);
    // Combinational through tx_ready so the next word lands without an idle cycle.
    assign bus.load_ready = ~in_shift | (last_bit & bus.tx_ready);
    assign load_fire = hs_fire(bus.load_valid, bus.load_ready);

    assign bus.tx_valid = in_shift;
    assign bus.busy     = in_shift;
    assign bus.tx_last  = last_bit;
    assign bus.tx_bit   = in_shift ? (MsbFirst ? shreg_q[Width-1] : shreg_q[0]) : IdleBit;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (load_fire) begin
            shreg_d = bus.D;
            state_d = STATE_SHIFT;
        end else if (tx_fire) begin
            if (cnt_zero) begin
                state_d = STATE_IDLE;
            end else if (MsbFirst) begin
                shreg_d = {shreg_q[Width-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[Width-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    bit_down_counter #(
        .Width (CntW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_fire),
        .load_val_i (LastIdx),
        .dec_i      (tx_fire),
        .zero_o     (cnt_zero)
    );

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial reader for an N-bit word register: accepts a parallel word through a valid/ready load handshake and emits it one bit per accepted transfer on a serial valid/ready output.
- Sits between the memory word storage and the serial/genetic-configuration links, mirroring the deserializer path that writes Words.
- Full throughput: back-to-back words with no idle cycle when the load side is ready.

Parameters:
- Width, 8, word width in bits (>= 2).
- MsbFirst, 1, 1 = emit bit Width-1 first; 0 = emit bit 0 first.
- IdleBit, 1'b0, value driven on tx_bit while tx_valid = 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  D holds a word to serialize.
- load_ready  output  1  serializer accepts D this cycle.
- D  input  Width  parallel word.
- tx_valid  output  1  tx_bit is valid.
- tx_ready  input  1  downstream accepts tx_bit this cycle.
- tx_bit  output  1  current serial bit.
- tx_last  output  1  tx_bit is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst = 1, regardless of clk:
  - state = IDLE, shift register = 0, bit counter = 0.
  - tx_valid = 0, tx_last = 0, busy = 0, tx_bit = IdleBit, load_ready = 1.
- Reset mid-word discards the word with no partial completion.
- Load and transfer handshakes:
  - Load fires on a rising clk edge when load_valid & load_ready.
  - A transfer fires on a rising clk edge when tx_valid & tx_ready.
- State IDLE:
  - load_ready = 1.
  - On load: shreg <= D, cnt <= Width-1, go to SHIFT.
  - First bit is valid the cycle after the load (latency 1).
- State SHIFT:
  - tx_valid = 1, busy = 1.
  - tx_bit = shreg[Width-1] if MsbFirst, else shreg[0].
  - tx_last = (cnt == 0).
  - On transfer with cnt != 0: shreg shifts toward the output end (zero fill) and cnt decrements.
  - On transfer with cnt == 0:
    - If load_valid, reload shreg/cnt from D and stay in SHIFT (back-to-back).
    - Otherwise go to IDLE.
- load_ready = (state == IDLE) | (state == SHIFT & tx_last & tx_ready).
  - This is a combinational path from tx_ready; it is documented and permitted.
- tx_ready low holds tx_bit, tx_last and cnt stable (no bit lost or repeated).
- load_valid while busy and not at the last accepted bit is ignored; D is not sampled.
- Counter width is clog2(Width). There is no wrap-around, because cnt never decrements below 0.
- Exactly Width transfers per loaded word; tx_last asserts on exactly one of them.

Decomposition:
- Shared include file memory/MemoryDefines.vh holds:
  - State encodings: STATE_IDLE = 1'b0, STATE_SHIFT = 1'b1.
  - Handshake-fire macro helpers.
- One sub-module, bit_down_counter (load, decrement enable, zero flag, async reset), reusable by the matching deserializer.
- Shift register and FSM are inline.

Test Plan:
- Reset and idle: rst pulse then release, no load -> tx_valid = 0, tx_bit = IdleBit, load_ready = 1, busy = 0; outputs clear asynchronously while rst is high with clk stopped.
- Basic MSB-first: Width = 8, D = 8'hA5 loaded, tx_ready = 1 -> tx_bit sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; tx_last only on the 8th; IDLE on the 9th cycle.
- LSB-first: MsbFirst = 0, D = 8'hA5 -> sequence 1,0,1,0,0,1,0,1 reversed by bit index, i.e. bits 0..7 = 1,0,1,0,0,1,0,1; tx_last on bit 7.
- Backpressure: D = 8'h3C, tx_ready toggled 1,0,0,1,... -> bits held stable during stalls; received word equals 8'h3C; load_valid held high mid-word does not change output.
- Back-to-back: D = 8'hFF then 8'h00 with load_valid constant -> 16 contiguous valid bits (8 ones then 8 zeros), load_ready pulses on cycle 8, no idle gap.
- Reset mid-word: load 8'hC3, assert rst after 3 transfers -> immediate IDLE, tx_valid = 0; after release, a new load of 8'h81 serializes correctly from its first bit.
